// File: rtl/pipe_regfile.sv
// Integer register file with write-through bypass and per-register pending-writer
// counters that let decode stall on a destination with too many writers in flight.
package pipe_regfile_pkg;
  typedef logic [31:0] ele_t;

  typedef struct packed {
    logic       rd_wen;
    logic [4:0] rd;
    ele_t       rd_wdata;
  } wb_req_t;
endpackage

module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  wb_req_t     wb_req_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  input  logic        issue_valid_i,
  input  logic        issue_rd_wen_i,
  input  logic [4:0]  issue_rd_i,
  output logic        issue_ready_o,
  input  logic        flush_i,
  output logic [31:0] wr_count_o
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [31:0]      regs_q   [NREG];
  logic [CNT_W-1:0] pend_q   [NREG];
  logic [CNT_W-1:0] pend_d   [NREG];
  logic [31:0]      wr_count_q, wr_count_d;

  logic wb_we;
  logic issue_fire;

  // x0 and any address beyond NREG are hardwired: never written, never tracked.
  function automatic logic in_rf(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREG);
  endfunction

  assign wb_we      = wb_req_i.rd_wen && in_rf(wb_req_i.rd);
  assign issue_fire = issue_valid_i && issue_rd_wen_i && issue_ready_o && in_rf(issue_rd_i);

  // A full counter only stalls decode when no writeback frees a slot this cycle.
  always_comb begin
    issue_ready_o = 1'b1;
    if (issue_rd_wen_i && in_rf(issue_rd_i)) begin
      if ((pend_q[issue_rd_i] == PEND_MAX) && !(wb_we && (wb_req_i.rd == issue_rd_i))) begin
        issue_ready_o = 1'b0;
      end
    end
  end

  always_comb begin
    rs1_data_o = '0;
    rs1_busy_o = 1'b0;
    if (in_rf(rs1_i)) begin
      if (wb_we && !rst_i && (wb_req_i.rd == rs1_i)) rs1_data_o = wb_req_i.rd_wdata;
      else                                            rs1_data_o = regs_q[rs1_i];
      rs1_busy_o = (pend_q[rs1_i] != '0) &&
                   !(wb_we && (wb_req_i.rd == rs1_i) && (pend_q[rs1_i] == PEND_ONE) &&
                     !(issue_fire && (issue_rd_i == rs1_i)));
    end
  end

  always_comb begin
    rs2_data_o = '0;
    rs2_busy_o = 1'b0;
    if (in_rf(rs2_i)) begin
      if (wb_we && !rst_i && (wb_req_i.rd == rs2_i)) rs2_data_o = wb_req_i.rd_wdata;
      else                                            rs2_data_o = regs_q[rs2_i];
      rs2_busy_o = (pend_q[rs2_i] != '0) &&
                   !(wb_we && (wb_req_i.rd == rs2_i) && (pend_q[rs2_i] == PEND_ONE) &&
                     !(issue_fire && (issue_rd_i == rs2_i)));
    end
  end

  // Flush wins over issue and writeback; a decrement at zero saturates.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc = issue_fire && (issue_rd_i == 5'(r));
      dec = wb_we && (wb_req_i.rd == 5'(r));
      pend_d[r] = pend_q[r];
      if (flush_i)                                   pend_d[r] = '0;
      else if (inc && !dec)                          pend_d[r] = pend_q[r] + PEND_ONE;
      else if (dec && !inc && (pend_q[r] != '0))     pend_d[r] = pend_q[r] - PEND_ONE;
    end
  end

  assign wr_count_d = wb_we ? (wr_count_q + 32'd1) : wr_count_q;
  assign wr_count_o = wr_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
      end
      if (wb_we) regs_q[wb_req_i.rd] <= wb_req_i.rd_wdata;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// Scenario bench for pipe_regfile: reads, bypass, x0, pending counters, flush,
// write-count wrap and asynchronous reset.
module tb_pipe_regfile;
  import pipe_regfile_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  wb_req_t     wb_req_i;
  logic [4:0]  rs1_i, rs2_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        rs1_busy_o, rs2_busy_o;
  logic        issue_valid_i, issue_rd_wen_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic        flush_i;
  logic [31:0] wr_count_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt;
  logic [31:0] exp_v;
  logic [31:0] rnd;

  pipe_regfile #(.NREG(32), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_req_i(wb_req_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .issue_valid_i(issue_valid_i), .issue_rd_wen_i(issue_rd_wen_i),
    .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .flush_i(flush_i), .wr_count_o(wr_count_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Driver tasks
  task automatic idle();
    wb_req_i       = '0;
    rs1_i          = 5'd0;
    rs2_i          = 5'd0;
    issue_valid_i  = 1'b0;
    issue_rd_wen_i = 1'b0;
    issue_rd_i     = 5'd0;
    flush_i        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_req_i.rd_wen   = 1'b1;
    wb_req_i.rd       = rd;
    wb_req_i.rd_wdata = data;
  endtask

  task automatic drive_issue(input logic valid, input logic [4:0] rd);
    issue_valid_i  = valid;
    issue_rd_wen_i = 1'b1;
    issue_rd_i     = rd;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    drive_wb(5'd1, 32'hFFFF_0000);
    rs1_i = 5'd1;
    rs2_i = 5'd2;
    drive_issue(1'b1, 5'd1);
    #2;
    n_checks++;
    if (rs1_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rs1_data: got %h want %h", rs1_data_o, 32'h0); end
    n_checks++;
    if (rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b want 00", rs1_busy_o, rs2_busy_o); end
    n_checks++;
    if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", issue_ready_o); end
    n_checks++;
    if (wr_count_o !== 32'h0) begin n_fail++; $display("FAIL reset_wr_count: got %h want 0", wr_count_o); end
    step();
    idle();
    rst_i   = 1'b0;
    exp_cnt = 32'h0;
    rs1_i   = 5'd1;
    #1;
    n_checks++;
    if (rs1_data_o !== 32'h0 || wr_count_o !== exp_cnt) begin
      n_fail++; $display("FAIL reset_discard_write: got data %h cnt %h want 0 0", rs1_data_o, wr_count_o);
    end
  endtask

  task automatic test_write_read();
    idle();
    rs1_i = 5'd1;
    rs2_i = 5'd2;
    #1;
    n_checks++;
    if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0 || rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL read_x1_x2: got %h %h busy %b%b want 0 0 busy 00", rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o);
    end
    drive_wb(5'd5, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_cnt++;
    step();
    idle();
    rs1_i = 5'd5;
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rs1_data_o !== exp_v) begin n_fail++; $display("FAIL write_x5: got %h want %h", rs1_data_o, exp_v); end
    n_checks++;
    if (wr_count_o !== exp_cnt) begin n_fail++; $display("FAIL wr_count_one: got %h want %h", wr_count_o, exp_cnt); end
    for (int i = 0; i < 4; i++) begin
      rnd = $urandom_range(32'hFFFF_FFFE, 1);
      drive_wb(5'(16 + i), rnd);
      exp_q.push_back(rnd);
      exp_cnt++;
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rs2_i = 5'(16 + i);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rs2_data_o !== exp_v) begin n_fail++; $display("FAIL random_rw x%0d: got %h want %h", 16 + i, rs2_data_o, exp_v); end
    end
  endtask

  task automatic test_bypass();
    idle();
    drive_wb(5'd7, 32'h1234_5678);
    rs2_i = 5'd7;
    rs1_i = 5'd8;
    exp_q.push_back(32'h1234_5678);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rs2_data_o !== exp_v) begin n_fail++; $display("FAIL bypass_rs2: got %h want %h", rs2_data_o, exp_v); end
    n_checks++;
    if (rs1_data_o !== 32'h0) begin n_fail++; $display("FAIL bypass_other_reg: got %h want 0", rs1_data_o); end
    exp_cnt++;
    step();
    idle();
  endtask

  task automatic test_x0();
    idle();
    drive_wb(5'd0, 32'hFFFF_FFFF);
    drive_issue(1'b1, 5'd0);
    rs1_i = 5'd0;
    #1;
    n_checks++;
    if (rs1_data_o !== 32'h0 || rs1_busy_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL x0_same_cycle: got %h busy %b ready %b want 0 0 1", rs1_data_o, rs1_busy_o, issue_ready_o);
    end
    step();
    idle();
    rs1_i = 5'd0;
    #1;
    n_checks++;
    if (rs1_data_o !== 32'h0 || rs1_busy_o !== 1'b0 || wr_count_o !== exp_cnt) begin
      n_fail++; $display("FAIL x0_after: got %h busy %b cnt %h want 0 0 %h", rs1_data_o, rs1_busy_o, wr_count_o, exp_cnt);
    end
  endtask

  task automatic test_scoreboard();
    for (int i = 0; i < 3; i++) begin
      idle();
      drive_issue(1'b1, 5'd3);
      #1;
      n_checks++;
      if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL issue_x3_%0d: got ready %b want 1", i, issue_ready_o); end
      step();
    end
    idle();
    rs1_i = 5'd3;
    drive_issue(1'b1, 5'd3);
    #1;
    n_checks++;
    if (rs1_busy_o !== 1'b1 || issue_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL pend_full: got busy %b ready %b want 1 0", rs1_busy_o, issue_ready_o);
    end
    step();
    idle();
    rs1_i = 5'd3;
    drive_issue(1'b0, 5'd3);
    drive_wb(5'd3, 32'h33);
    exp_cnt++;
    #1;
    n_checks++;
    if (rs1_busy_o !== 1'b1 || issue_ready_o !== 1'b1 || rs1_data_o !== 32'h33) begin
      n_fail++; $display("FAIL wb_x3_full: got busy %b ready %b data %h want 1 1 33", rs1_busy_o, issue_ready_o, rs1_data_o);
    end
    step();
    idle();
    drive_issue(1'b1, 5'd3);
    drive_wb(5'd3, 32'h44);
    exp_cnt++;
    step();
    idle();
    rs1_i = 5'd3;
    drive_wb(5'd3, 32'h55);
    exp_cnt++;
    #1;
    n_checks++;
    if (rs1_busy_o !== 1'b1) begin n_fail++; $display("FAIL pend_two_first_wb: got busy %b want 1", rs1_busy_o); end
    step();
    drive_wb(5'd3, 32'h66);
    exp_cnt++;
    #1;
    n_checks++;
    if (rs1_busy_o !== 1'b0) begin n_fail++; $display("FAIL pend_last_wb: got busy %b want 0", rs1_busy_o); end
    step();
    drive_wb(5'd3, 32'h77);
    exp_q.push_back(32'h77);
    exp_cnt++;
    step();
    idle();
    rs1_i = 5'd3;
    drive_issue(1'b0, 5'd3);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rs1_busy_o !== 1'b0 || issue_ready_o !== 1'b1 || rs1_data_o !== exp_v || wr_count_o !== exp_cnt) begin
      n_fail++; $display("FAIL underflow: got busy %b ready %b data %h cnt %h want 0 1 %h %h",
                         rs1_busy_o, issue_ready_o, rs1_data_o, wr_count_o, exp_v, exp_cnt);
    end
  endtask

  task automatic test_mixed();
    idle();
    drive_issue(1'b1, 5'd9);
    step();
    idle();
    drive_issue(1'b1, 5'd8);
    drive_wb(5'd9, 32'h99);
    exp_q.push_back(32'h99);
    exp_cnt++;
    rs1_i = 5'd8;
    rs2_i = 5'd9;
    #1;
    n_checks++;
    if (rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL mixed_same_cycle: got busy %b%b want 00", rs1_busy_o, rs2_busy_o);
    end
    step();
    idle();
    rs1_i = 5'd8;
    rs2_i = 5'd9;
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rs1_busy_o !== 1'b1 || rs2_busy_o !== 1'b0 || rs2_data_o !== exp_v) begin
      n_fail++; $display("FAIL mixed_after: got busy %b%b data %h want 10 %h", rs1_busy_o, rs2_busy_o, rs2_data_o, exp_v);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      idle();
      drive_issue(1'b1, 5'd4);
      step();
    end
    idle();
    rs1_i = 5'd4;
    #1;
    n_checks++;
    if (rs1_busy_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b want 1", rs1_busy_o); end
    flush_i = 1'b1;
    drive_issue(1'b1, 5'd4);
    drive_wb(5'd4, 32'hA5);
    exp_q.push_back(32'hA5);
    exp_cnt++;
    step();
    idle();
    rs1_i = 5'd4;
    rs2_i = 5'd8;
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_busy: got %b%b want 00", rs1_busy_o, rs2_busy_o);
    end
    n_checks++;
    if (rs1_data_o !== exp_v || wr_count_o !== exp_cnt) begin
      n_fail++; $display("FAIL flush_write: got %h cnt %h want %h %h", rs1_data_o, wr_count_o, exp_v, exp_cnt);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    idle();
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    n_checks++;
    if (wr_count_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", wr_count_o); end
    rnd = $urandom_range(32'hFFFF_FFFE, 1);
    drive_wb(5'd10, rnd);
    exp_q.push_back(rnd);
    step();
    idle();
    rs1_i = 5'd10;
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (wr_count_o !== 32'h0 || rs1_data_o !== exp_v) begin
      n_fail++; $display("FAIL wrap: got cnt %h data %h want 0 %h", wr_count_o, rs1_data_o, exp_v);
    end
    drive_issue(1'b1, 5'd10);
    step();
    idle();
    rs1_i = 5'd10;
    rs2_i = 5'd11;
    drive_issue(1'b0, 5'd10);
    drive_wb(5'd11, 32'hCAFE_F00D);
    #3;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (rs1_data_o !== 32'h0 || rs1_busy_o !== 1'b0 || rs2_data_o !== 32'h0 ||
        issue_ready_o !== 1'b1 || wr_count_o !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got d1 %h b1 %b d2 %h ready %b cnt %h want 0 0 0 1 0",
                         rs1_data_o, rs1_busy_o, rs2_data_o, issue_ready_o, wr_count_o);
    end
    step();
    idle();
    rst_i = 1'b0;
    rs2_i = 5'd11;
    #1;
    n_checks++;
    if (rs2_data_o !== 32'h0 || wr_count_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_drop_write: got %h cnt %h want 0 0", rs2_data_o, wr_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_mixed();
    test_flush();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 The block SHALL take parameter NREG, default 32, giving the number of architectural integer registers.
REQ-002 The block SHALL take parameter CNT_W, default 2, giving the width of each per-register pending-write counter.
REQ-003 Port clk_i, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port wb_req_i, input, wb_req_t: writeback request with fields rd_wen, rd[4:0] and rd_wdata (ele_t, 32 bit); this is the port driven by the writeback stage.
REQ-006 Port rs1_i, input, 5 bits: read port 1 address.
REQ-007 Port rs2_i, input, 5 bits: read port 2 address.
REQ-008 Port rs1_data_o, output, 32 bits: read port 1 data.
REQ-009 Port rs2_data_o, output, 32 bits: read port 2 data.
REQ-010 Port rs1_busy_o, output, 1 bit: rs1 has an in-flight writer.
REQ-011 Port rs2_busy_o, output, 1 bit: rs2 has an in-flight writer.
REQ-012 Port issue_valid_i, input, 1 bit: the decode stage issues an instruction this cycle.
REQ-013 Port issue_rd_wen_i, input, 1 bit: the issued instruction writes rd.
REQ-014 Port issue_rd_i, input, 5 bits: destination register of the issued instruction.
REQ-015 Port issue_ready_o, output, 1 bit: an issue to issue_rd_i is accepted this cycle.
REQ-016 Port flush_i, input, 1 bit: discard all in-flight writer tracking.
REQ-017 Port wr_count_o, output, 32 bits: count of committed register writes; wraps around.

Function
REQ-018 Register file: a NREG x 32 array; on a rising edge with wb_req_i.rd_wen=1 and rd!=0, reg[rd] SHALL be set to rd_wdata.
REQ-019 x0: reads of register 0 SHALL return 0, its busy flag SHALL be 0, and writes or issues to register 0 SHALL have no effect.
REQ-020 Reads: rsN_data_o SHALL be combinational; when wb rd_wen=1, rd=rsN and rsN!=0, the output SHALL be rd_wdata (same-cycle write-through bypass), otherwise reg[rsN].
REQ-021 Pending counter: each register SHALL hold a counter pend[r] of CNT_W bits.
REQ-022 Counter increment: an issue (issue_valid_i & issue_rd_wen_i & issue_ready_o, rd!=0) SHALL increment pend[issue_rd_i].
REQ-023 Counter decrement: a writeback with rd_wen=1 and rd!=0 SHALL decrement pend[rd].
REQ-024 Simultaneous increment and decrement of the same register SHALL leave its counter unchanged.
REQ-025 Increment and decrement of different registers in the same cycle SHALL both take effect.
REQ-026 A decrement when pend=0 SHALL leave the counter at 0 and SHALL NOT wrap; the register write still occurs.
REQ-027 Busy: rsN_busy_o SHALL equal (pend[rsN]!=0) AND NOT (a same-cycle writeback to rsN that brings pend[rsN] to 0).
REQ-028 Saturation: issue_ready_o SHALL be 0 when issue_rd_wen_i=1, issue_rd_i!=0 and pend[issue_rd_i] is at its maximum (2^CNT_W-1) with no same-cycle writeback to that register; otherwise it SHALL be 1.
REQ-029 Flush: flush_i=1 SHALL clear all pend[] to 0 on the next edge and SHALL take priority over any same-cycle issue or decrement.
REQ-030 Flush SHALL NOT block a same-cycle writeback data write.
REQ-031 wr_count_o SHALL increment by 1 on each writeback with rd_wen=1 and rd!=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 All outputs SHALL be glitch-free functions of state and the current-cycle inputs; there is no added latency beyond that of REQ-020.

Reset
REQ-033 While rst_i=1: all registers SHALL be 0, all pend[] 0, wr_count_o 0, busy outputs 0, and issue_ready_o 1.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight tracking and any same-cycle write.

Verification
REQ-035 Reset then read x1/x2 -> data 0, busy 0; write x5=0xDEADBEEF -> next cycle rs1=5 reads 0xDEADBEEF, wr_count_o=1.
REQ-036 Bypass: wb write x7=0x12345678 with rs2_i=7 in the same cycle -> rs2_data_o=0x12345678 combinationally.
REQ-037 x0: write x0=0xFFFFFFFF and issue rd=0 -> reads 0, busy 0, wr_count_o unchanged.
REQ-038 Scoreboard: issue x3 three times -> pend=3, busy 1, 4th issue ready=0; one writeback to x3 -> pend=2; a simultaneous issue and writeback on x3 -> pend stays 2.
REQ-039 Flush: pend[x4]=2, flush plus a same-cycle writeback x4=0xA5 -> pend 0, busy 0, reg[x4]=0xA5.
REQ-040 Wrap: preload wr_count_o=0xFFFFFFFF by forced writes, one more write -> wr_count_o=0; async reset asserted mid-cycle -> all outputs at reset values immediately.
